// File: rtl/ctr_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctr_driver_if : request handshake and counter-chain bus for ctr_driver |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ctr_driver_if;
    logic        start;
    logic        dir;
    logic [11:0] value;
    logic        abort;
    logic [11:0] d;
    logic        sel2;
    logic        sel1;
    logic        nCryIn;
    logic [2:0]  nCryOut;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] ticks;

    // master: requester plus the external counter chain
    modport master (
        output start, dir, value, abort, nCryOut,
        input  d, sel2, sel1, nCryIn, busy, done, err, ticks
    );

    modport slave (
        input  start, dir, value, abort, nCryOut,
        output d, sel2, sel1, nCryIn, busy, done, err, ticks
    );
endinterface
`default_nettype wire

// File: rtl/ctr_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctr_driver : loads a 3-nibble hex counter chain and runs it to 0/FFF  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ctr_driver (
    input  wire logic   clk,
    input  wire logic   nReset,
    ctr_driver_if.slave bus
);
    localparam logic [1:0]  c_SEL_LOAD   = 2'b00;
    localparam logic [1:0]  c_SEL_INC    = 2'b01;
    localparam logic [1:0]  c_SEL_DEC    = 2'b10;
    localparam logic [1:0]  c_SEL_HOLD   = 2'b11;
    localparam logic [12:0] c_TICK_LIMIT = 13'd4097;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RELEASE = 3'd3,
        S_COUNT   = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sel;
    logic        r_ncryin;
    logic [11:0] r_d;
    logic        r_dir;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [12:0] r_ticks;

    logic        w_term;
    logic [12:0] w_ticks_inc;

    assign w_term      = (bus.nCryOut == 3'b000);
    assign w_ticks_inc = r_ticks + 13'd1;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_sel    <= c_SEL_HOLD;
            r_ncryin <= 1'b1;
            r_d      <= 12'h000;
            r_dir    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ticks  <= 13'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_SETUP;
                        r_dir    <= bus.dir;
                        r_d      <= bus.value;
                        r_ticks  <= 13'd0;
                        r_sel    <= c_SEL_LOAD;
                        r_ncryin <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state  <= S_STROBE;
                    r_ncryin <= 1'b0;
                end
                S_STROBE: begin
                    r_state  <= S_RELEASE;
                    r_sel    <= c_SEL_HOLD;
                    r_ncryin <= 1'b1;
                end
                S_RELEASE: begin
                    r_state <= S_COUNT;
                    r_sel   <= r_dir ? c_SEL_INC : c_SEL_DEC;
                end
                S_COUNT: begin
                    if (w_term) begin
                        r_state <= S_FIN;
                        r_sel   <= c_SEL_HOLD;
                        r_done  <= 1'b1;
                    end else begin
                        // every clk here with term low is a real chain edge
                        r_ticks <= w_ticks_inc;
                        if (w_ticks_inc == c_TICK_LIMIT) begin
                            r_state <= S_IDLE;
                            r_sel   <= c_SEL_HOLD;
                            r_d     <= 12'h000;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_d     <= 12'h000;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sel    <= c_SEL_HOLD;
                    r_ncryin <= 1'b1;
                    r_d      <= 12'h000;
                    r_busy   <= 1'b0;
                end
            endcase

            // abort overrides every transition above but keeps the tick count
            if (r_state != S_IDLE && bus.abort) begin
                r_state  <= S_IDLE;
                r_sel    <= c_SEL_HOLD;
                r_ncryin <= 1'b1;
                r_d      <= 12'h000;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

    assign bus.nCryIn = (r_state == S_COUNT) ? w_term : r_ncryin;
    assign bus.sel2   = r_sel[1];
    assign bus.sel1   = r_sel[0];
    assign bus.d      = r_d;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.ticks  = r_ticks;
endmodule
`default_nettype wire

// File: tb/tb_ctr_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ctr_driver : directed bench with a behavioural 3-nibble chain      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ctr_driver;
    logic clk    = 1'b0;
    logic nReset = 1'b0;

    ctr_driver_if bus ();

    ctr_driver dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Chain model: loads on falling nCryIn in LOAD, counts on clk while nCryIn low
    logic [11:0] load_val = 12'h000;
    logic [7:0]  load_gen = 8'd0;
    logic [7:0]  seen_gen = 8'd0;
    logic [11:0] delta    = 12'h000;
    int          edges    = 0;
    bit          stuck    = 1'b0;
    logic [11:0] chain;
    logic [3:0]  w_tn;
    logic [1:0]  sel;

    assign sel   = {bus.sel2, bus.sel1};
    assign chain = load_val + delta;
    assign w_tn  = (sel == 2'b01) ? 4'hF : 4'h0;
    assign bus.nCryOut = stuck ? 3'b111 :
                         {chain[11:8] != w_tn, chain[7:4] != w_tn, chain[3:0] != w_tn};

    always @(negedge bus.nCryIn) begin
        if (sel == 2'b00) begin
            load_val <= bus.d;
            load_gen <= load_gen + 8'd1;
        end
    end

    always @(posedge clk) begin
        if (seen_gen != load_gen) begin
            seen_gen <= load_gen;
            delta    <= 12'h000;
        end else if (!bus.nCryIn && sel == 2'b01) begin
            delta <= delta + 12'h001;
            edges <= edges + 1;
        end else if (!bus.nCryIn && sel == 2'b10) begin
            delta <= delta - 12'h001;
            edges <= edges + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // k counts rising edges since the edge that accepted start
    task automatic run(input logic dirv, input logic [11:0] val, input bit abort_too,
                       input int abort_at, input int restart_at, input int max_cyc,
                       output int lat, output int done_cyc, output int err_cyc,
                       output int both, output logic [11:0] chain_ld);
        lat = -1; done_cyc = 0; err_cyc = 0; both = 0; chain_ld = 12'h000;
        @(negedge clk);
        bus.start = 1'b1; bus.dir = dirv; bus.value = val; bus.abort = abort_too;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (k == 2) chain_ld = chain;
            if (bus.done) begin done_cyc++; if (lat < 0) lat = k; end
            if (bus.err)  begin err_cyc++;  if (lat < 0) lat = k; end
            if (bus.done && bus.err) both++;
            if (!bus.busy) break;
            bus.abort = (k == abort_at);
            bus.start = (k == restart_at);
            if (k == restart_at) begin
                bus.value = 12'h123;
                bus.dir   = ~dirv;
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("run_ends_idle", bus.busy, 0);
    endtask

    int          lat, dc, ec, both, e0;
    logic [11:0] cl, saved;

    initial begin
        bus.start = 1'b0; bus.dir = 1'b0; bus.value = 12'h000; bus.abort = 1'b0;
        #12;
        check("rst_sel",    sel, 2'b11);
        check("rst_ncryin", bus.nCryIn, 1);
        check("rst_d",      bus.d, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.done, 0);
        check("rst_err",    bus.err, 0);
        check("rst_ticks",  bus.ticks, 0);
        @(negedge clk);
        nReset = 1'b1;

        // down from 5
        e0 = edges;
        run(1'b0, 12'h005, 1'b0, -1, -1, 50, lat, dc, ec, both, cl);
        check("dn5_load",  cl, 12'h005);
        check("dn5_lat",   lat, 9);
        check("dn5_ticks", bus.ticks, 5);
        check("dn5_chain", chain, 12'h000);
        check("dn5_edges", edges - e0, 5);
        check("dn5_done",  dc, 1);
        check("dn5_err",   ec, 0);
        check("dn5_both",  both, 0);

        // up from FFD, abort raised together with start in IDLE
        run(1'b1, 12'hFFD, 1'b1, -1, -1, 50, lat, dc, ec, both, cl);
        check("upfd_load",  cl, 12'hFFD);
        check("upfd_lat",   lat, 6);
        check("upfd_ticks", bus.ticks, 2);
        check("upfd_chain", chain, 12'hFFF);
        check("upfd_done",  dc, 1);
        check("upfd_err",   ec, 0);

        // already terminal: zero down
        e0 = edges;
        run(1'b0, 12'h000, 1'b0, -1, -1, 50, lat, dc, ec, both, cl);
        check("zero_lat",   lat, 4);
        check("zero_ticks", bus.ticks, 0);
        check("zero_edges", edges - e0, 0);
        check("zero_done",  dc, 1);

        // abort at k=100, ignored start at k=50
        run(1'b0, 12'h800, 1'b0, 100, 50, 300, lat, dc, ec, both, cl);
        check("abt_sel",    sel, 2'b11);
        check("abt_ncryin", bus.nCryIn, 1);
        check("abt_ticks",  bus.ticks, 98);
        check("abt_chain",  chain, 12'h79E);
        check("abt_done",   dc, 0);
        check("abt_err",    ec, 0);
        repeat (3) @(negedge clk);
        check("abt_frozen", chain, 12'h79E);

        // carry-outs stuck high: timeout
        stuck = 1'b1;
        run(1'b0, 12'h010, 1'b0, -1, -1, 4200, lat, dc, ec, both, cl);
        check("to_lat",   lat, 4100);
        check("to_err",   ec, 1);
        check("to_done",  dc, 0);
        check("to_ticks", bus.ticks, 4097);
        check("to_sel",   sel, 2'b11);
        @(negedge clk);
        check("to_errpulse", bus.err, 0);
        check("to_hold",     bus.ticks, 4097);
        stuck = 1'b0;

        // asynchronous reset mid-count
        @(negedge clk);
        bus.start = 1'b1; bus.dir = 1'b0; bus.value = 12'h100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_chain", chain, 12'h0EF);
        saved = chain;
        #2 nReset = 1'b0;
        #1;
        check("ar_sel",    sel, 2'b11);
        check("ar_ncryin", bus.nCryIn, 1);
        check("ar_d",      bus.d, 0);
        check("ar_busy",   bus.busy, 0);
        check("ar_ticks",  bus.ticks, 0);
        check("ar_done",   bus.done, 0);
        check("ar_err",    bus.err, 0);
        check("ar_chain",  chain, saved);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        run(1'b0, 12'h003, 1'b0, -1, -1, 50, lat, dc, ec, both, cl);
        check("post_lat",   lat, 7);
        check("post_ticks", bus.ticks, 3);
        check("post_chain", chain, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/ctr_driver.md
CTR_DRIVER -- requirements
Module: ctr_driver

Interface
REQ-001 Ports SHALL be, one per line, name direction width meaning; clock and reset first:
clk  in  1  single system clock, all state on rising edge
nReset  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
dir  in  1  0 = count down to 0x000, 1 = count up to 0xFFF
value  in  12  start value, captured when start is accepted
abort  in  1  forces return to IDLE from any non-IDLE state
d  out  12  load data to counter chain (nibble k on d[4k+3:4k])
sel2, sel1  out  1 each  chain mode: 00 LOAD, 01 INC, 10 DEC, 11 HOLD
nCryIn  out  1  active-low carry-in to least-significant nibble
nCryOut  in  3  active-low carry-out of each nibble, bit k = nibble k
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on timeout
ticks  out  13  counter edges issued in the current or last run

Function
REQ-002 The block SHALL drive an external chain of three hex counter nibbles with the 00/01/10/11 mode encoding above.
REQ-003 In LOAD/HOLD the chain's clock is the falling edge of nCryIn; in INC/DEC it is clk, gated by nCryIn low.
REQ-004 States: IDLE, SETUP, STROBE, RELEASE, COUNT, FIN.
REQ-005 IDLE: sel=11, nCryIn=1, d=0; start=1 captures value and dir into registers, clears ticks, and moves to SETUP.
REQ-006 SETUP: sel=00, d=captured value, nCryIn=1; the block moves to STROBE after 1 cycle.
REQ-007 STROBE: sel=00, d held, nCryIn=0 (this falling edge loads the chain); the block moves to RELEASE after 1 cycle.
REQ-008 RELEASE: sel=11, nCryIn=1, d held; the block moves to COUNT after 1 cycle.
REQ-009 COUNT: sel=10 when dir=0 and sel=01 when dir=1.
REQ-010 COUNT: term = all three nCryOut bits low; nCryIn SHALL be combinationally equal to term, so no counting edge is enabled once the chain reaches terminal.
REQ-011 COUNT: ticks increments on each clk with term=0.
REQ-012 COUNT: term=1 moves the block to FIN.
REQ-013 COUNT: ticks reaching 4097 with term=0 moves the block to IDLE and pulses err; sel goes to 11 the same cycle.
REQ-014 FIN: sel=11, nCryIn=1; done pulses for exactly 1 cycle; the block moves to IDLE.
REQ-015 Latency: a down-count from N asserts done N+4 cycles after start is accepted; an up-count asserts done (0xFFF-N)+4 cycles after.
REQ-016 Boundary, value=0 with dir=0 (or 0xFFF with dir=1): term holds on entry to COUNT, ticks=0, and done follows in the minimum 4 cycles.
REQ-017 abort in any non-IDLE state moves the block to IDLE on the next edge with sel=11 and nCryIn=1, and pulses neither done nor err; ticks is retained.
REQ-018 abort and start asserted together in IDLE: start wins and abort is ignored.
REQ-019 start outside IDLE SHALL be ignored, with no queuing.
REQ-020 ticks SHALL saturate at 4097 and hold its value until the next accepted start.
REQ-021 done and err SHALL never be asserted together.

Reset
REQ-022 nReset low asynchronously forces IDLE, sel2=sel1=1, nCryIn=1, d=0, busy=0, done=0, err=0, ticks=0.
REQ-023 Reset asserted mid-COUNT SHALL drive HOLD immediately and leave the chain contents untouched.
REQ-024 Release of nReset is synchronous to clk; the first start is accepted on the first rising edge after release.

Verification
REQ-025 Bench: dir=0, value=0x005, chain model attached -> chain reads 0x005 after STROBE; ticks=5; done pulses 9 cycles after start; chain reads 0x000.
REQ-026 Bench: dir=1, value=0xFFD -> ticks=2, chain reads 0xFFF, done pulse, err=0.
REQ-027 Bench: dir=0, value=0x000 -> no INC/DEC edge issued, ticks=0, done pulses 4 cycles after start.
REQ-028 Bench: value=0x800 down, abort in cycle 100 -> IDLE next cycle, sel=11, chain frozen at 0x800-(ticks), no done, no err.
REQ-029 Bench: chain model with nCryOut stuck high -> err pulses after ticks=4097, done never asserts.
REQ-030 Bench: nReset pulsed low mid-COUNT -> outputs reach reset values with no clk edge; start is accepted after release.
